// File: rtl/requant_writeback_pkg.sv
// Shared constants for the requantise/write-back stage: lane geometry,
// FSM state encodings and the int8 saturation limits.
package requant_writeback_pkg;
  localparam int LANES   = 64;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int ADDR_W  = 10;
  localparam int RD_LAT  = 2;
  localparam int DIM_W   = 6;
  localparam int SHIFT_W = 5;
  localparam int TOT_W   = 12;

  localparam int SAT_MIN   = -128;
  localparam int SAT_MAX   = 127;
  localparam int SHIFT_MAX = 23;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;
endpackage

// File: rtl/requant_writeback_if.sv
// Command, BRAM read/write and status signals of the write-back stage.
// master = layer controller plus BRAM side, slave = requant_writeback.
interface requant_writeback_if;
  import requant_writeback_pkg::*;

  logic                     start;
  logic [DIM_W-1:0]         H;
  logic [DIM_W-1:0]         W;
  logic [SHIFT_W-1:0]       shift;
  logic                     relu_en;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [LANES*ACC_W-1:0]   rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [LANES*OUT_W-1:0]   wr_data;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, H, W, shift, relu_en, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, H, W, shift, relu_en, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/requant_writeback_lane.sv
// One lane of the requantiser: stage p0 rounds and shifts the accumulator,
// stage p1 applies optional ReLU and saturates to int8.
module requant_writeback_lane
  import requant_writeback_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [ACC_W-1:0]  x,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu_en,
  input  logic                     valid,
  output logic signed [OUT_W-1:0]  q
);
  localparam int YW = ACC_W + 1;

  // Half-up rounding: one guard bit keeps x + 2^(s-1) from overflowing.
  function automatic logic signed [YW-1:0] round_shift(
    input logic signed [ACC_W-1:0] a,
    input logic [SHIFT_W-1:0]      s
  );
    logic signed [YW-1:0] ext;
    logic signed [YW-1:0] bias;
    ext = {a[ACC_W-1], a};
    if (s == '0) return ext;
    bias = YW'(1) <<< (s - 5'd1);
    return (ext + bias) >>> s;
  endfunction

  function automatic logic signed [OUT_W-1:0] relu_sat(
    input logic signed [YW-1:0] y,
    input logic                 relu
  );
    logic signed [YW-1:0] r;
    r = (relu && y < 0) ? '0 : y;
    if (r > YW'(SAT_MAX)) return OUT_W'(SAT_MAX);
    if (r < YW'(SAT_MIN)) return OUT_W'(SAT_MIN);
    return r[OUT_W-1:0];
  endfunction

  logic signed [YW-1:0]    y_p0_q, y_p0_d;
  logic                    vld_p0_q, vld_p0_d;
  logic signed [OUT_W-1:0] q_p1_q, q_p1_d;

  always_comb begin
    vld_p0_d = valid;
    y_p0_d   = valid ? round_shift(x, shift) : y_p0_q;
    q_p1_d   = vld_p0_q ? relu_sat(y_p0_q, relu_en) : q_p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0_q <= 1'b0;
    else     vld_p0_q <= vld_p0_d;
  end

  // stage p0 -> p1 data registers
  always_ff @(posedge clk) begin
    y_p0_q <= y_p0_d;
    q_p1_q <= q_p1_d;
  end

  assign q = q_p1_q;
endmodule

// File: rtl/requant_writeback.sv
// Reads a finished layer's accumulator words, requantises all lanes and
// writes the int8 words back at the same address, one word per cycle.
module requant_writeback
  import requant_writeback_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  requant_writeback_if.slave  bus
);
  localparam int DEPTH = RD_LAT + 2;

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [TOT_W-1:0]     total_q, total_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic                 err_q, err_d;
  logic [DEPTH-1:0]     vld_p_q, vld_p_d;
  logic [ADDR_W-1:0]    addr_p_q [DEPTH];
  logic [ADDR_W-1:0]    addr_p_d [DEPTH];
  logic [TOT_W-1:0]     total_in;
  logic                 issue;
  logic [LANES*OUT_W-1:0] lane_q;

  assign issue    = (state_q == ST_RUN);
  assign total_in = TOT_W'(bus.H) * TOT_W'(bus.W);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    total_d = total_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    err_d   = err_q;
    // The write-stage bit is dropped here, so DRAIN leaves on the last write.
    vld_p_d = {vld_p_q[DEPTH-2:0], issue};
    addr_p_d[0] = idx_q;
    for (int k = 1; k < DEPTH; k++) addr_p_d[k] = addr_p_q[k-1];

    case (state_q)
      ST_IDLE: if (bus.start) begin
        total_d = total_in;
        shift_d = (bus.shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : bus.shift;
        relu_d  = bus.relu_en;
        idx_d   = '0;
        err_d   = 1'b0;
        if (bus.H == '0 || bus.W == '0 || total_in > TOT_W'(1 << ADDR_W)) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        idx_d = idx_q + 1'b1;
        if (TOT_W'(idx_q) == total_q - 12'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (vld_p_d == '0) state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      total_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_p_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
      vld_p_q <= vld_p_d;
    end
  end

  // address delay line, aligned with vld_p_q
  always_ff @(posedge clk) begin
    addr_p_q <= addr_p_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_writeback_lane u_lane (
      .clk     (clk),
      .rst     (rst_n),
      .x       (bus.rd_data[i*ACC_W +: ACC_W]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .valid   (vld_p_q[RD_LAT-1]),
      .q       (lane_q[i*OUT_W +: OUT_W])
    );
  end

  assign bus.rd_en   = issue;
  assign bus.rd_addr = issue ? idx_q : '0;
  assign bus.wr_en   = vld_p_q[DEPTH-1];
  assign bus.wr_addr = vld_p_q[DEPTH-1] ? addr_p_q[DEPTH-1] : '0;
  assign bus.wr_data = vld_p_q[DEPTH-1] ? lane_q : '0;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_FIN);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_requant_writeback.sv
// Bench for requant_writeback: BRAM read model, write/done monitor and a
// real-arithmetic reference for the per-lane requantisation.
module tb_requant_writeback;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  requant_writeback_if bus();
  requant_writeback dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1535:0] mem [0:1023];
  logic [1535:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= bus.rd_en ? mem[bus.rd_addr] : '0;
    rd_p1 <= rd_p0;
  end
  assign bus.rd_data = rd_p1;

  typedef struct { int cyc; int addr; logic [511:0] data; } wr_t;
  wr_t wr_q[$];
  int  rd_cyc[$];
  int  rd_adr[$];
  int  done_cyc[$];

  always @(negedge clk) begin
    if (bus.rd_en) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(bus.rd_addr)); end
    if (bus.wr_en) wr_q.push_back('{cyc: cyc, addr: int'(bus.wr_addr), data: bus.wr_data});
    if (bus.done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: round(x / 2^s) with ties toward +inf, then ReLU, then clamp.
  function automatic logic [511:0] model(input logic [1535:0] w, input logic [4:0] sh, input logic relu);
    logic [511:0] r;
    int s, x, yi;
    real y;
    s = (sh > 5'd23) ? 23 : int'(sh);
    for (int i = 0; i < 64; i++) begin
      x  = int'($signed(w[i*24 +: 24]));
      y  = $floor(real'(x) / real'(longint'(1) << s) + 0.5);
      yi = int'(y);
      if (relu && yi < 0) yi = 0;
      if (yi > 127) yi = 127;
      if (yi < -128) yi = -128;
      r[i*8 +: 8] = 8'(yi);
    end
    return r;
  endfunction

  task automatic fill(input int n);
    logic [23:0] v;
    for (int a = 0; a < n; a++)
      for (int l = 0; l < 64; l++) begin
        if ($urandom_range(0, 1) == 1) v = 24'($urandom);
        else v = 24'($urandom_range(0, 8191)) - 24'd4096;
        mem[a][l*24 +: 24] = v;
      end
  endtask

  task automatic clear_mon();
    wr_q.delete(); rd_cyc.delete(); rd_adr.delete(); done_cyc.delete();
  endtask

  task automatic run_pass(input int h, input int w, input int sh, input bit relu, input int restart);
    int start_cyc, n, budget;
    bit illegal;
    illegal = (h == 0 || w == 0 || h * w > 1024);
    n = illegal ? 0 : h * w;
    budget = n + 40;
    clear_mon();
    bus.H = 6'(h); bus.W = 6'(w); bus.shift = 5'(sh); bus.relu_en = relu;
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) begin
      if (i == restart) begin
        bus.start = 1'b1; bus.H = 6'd1; bus.W = 6'd1; bus.shift = 5'd0;
      end
      tick();
      bus.start = 1'b0;
    end
    chk("done_seen", done_cyc.size() > 0, 1);
    repeat (8) tick();
    chk("err", bus.err, illegal);
    chk("busy_end", bus.busy, 0);
    chk("n_rd", rd_adr.size(), n);
    for (int i = 0; i < rd_adr.size() && i < n; i++) begin
      chk("rd_addr", rd_adr[i], i);
      chk("rd_cyc", rd_cyc[i], start_cyc + 1 + i);
    end
    chk("n_wr", wr_q.size(), n);
    for (int i = 0; i < wr_q.size() && i < n; i++) begin
      chk("wr_addr", wr_q[i].addr, i);
      chk("wr_cyc", wr_q[i].cyc, start_cyc + 1 + i + RD_LAT + 2);
      chk("wr_data", wr_q[i].data, model(mem[i], 5'(sh), relu));
    end
    chk("n_done", done_cyc.size(), 1);
    if (done_cyc.size() > 0)
      chk("done_cyc", done_cyc[0], (n == 0) ? start_cyc + 1 : start_cyc + n + RD_LAT + 3);
  endtask

  typedef struct { logic [23:0] x; logic [4:0] sh; logic relu; logic [7:0] q; } vec_t;
  vec_t tab [14];

  initial begin
    tab[0]  = '{x: 24'd24,      sh: 5'd4,  relu: 1'b0, q: 8'd2};
    tab[1]  = '{x: 24'hFFFFE8,  sh: 5'd4,  relu: 1'b0, q: 8'hFF};
    tab[2]  = '{x: 24'd8,       sh: 5'd4,  relu: 1'b0, q: 8'd1};
    tab[3]  = '{x: 24'hFFFFF7,  sh: 5'd4,  relu: 1'b0, q: 8'hFF};
    tab[4]  = '{x: 24'd5,       sh: 5'd0,  relu: 1'b0, q: 8'd5};
    tab[5]  = '{x: 24'h7FFFFF,  sh: 5'd0,  relu: 1'b0, q: 8'h7F};
    tab[6]  = '{x: 24'h800000,  sh: 5'd0,  relu: 1'b0, q: 8'h80};
    tab[7]  = '{x: 24'hFFFF80,  sh: 5'd0,  relu: 1'b1, q: 8'h00};
    tab[8]  = '{x: 24'd100,     sh: 5'd0,  relu: 1'b1, q: 8'd100};
    tab[9]  = '{x: 24'h400000,  sh: 5'd31, relu: 1'b0, q: 8'd1};
    tab[10] = '{x: 24'h3FFFFF,  sh: 5'd31, relu: 1'b0, q: 8'd0};
    tab[11] = '{x: 24'hFFFFE7,  sh: 5'd4,  relu: 1'b0, q: 8'hFE};
    tab[12] = '{x: 24'hFFFFF8,  sh: 5'd4,  relu: 1'b0, q: 8'h00};
    tab[13] = '{x: 24'h7FFFFF,  sh: 5'd4,  relu: 1'b0, q: 8'h7F};

    bus.start = 1'b0; bus.H = '0; bus.W = '0; bus.shift = '0; bus.relu_en = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("rst_ctrl", {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err}, 0);
    chk("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    chk("rst_wdata", bus.wr_data, 0);
    rst_n = 1'b0;
    tick();

    // basic pass: lane0 = 256 everywhere, shift 4
    fill(6);
    for (int a = 0; a < 6; a++) mem[a][23:0] = 24'd256;
    run_pass(2, 3, 4, 1'b0, -1);
    for (int i = 0; i < wr_q.size(); i++) chk("basic_lane0", wr_q[i].data[7:0], 8'd16);

    // lane arithmetic vectors, one 1x1 pass each
    foreach (tab[i]) begin
      fill(1);
      mem[0][23:0] = tab[i].x;
      run_pass(1, 1, int'(tab[i].sh), tab[i].relu, -1);
      if (wr_q.size() == 0) chk("vec_write", 0, 1);
      else chk($sformatf("vec%0d_lane0", i), wr_q[0].data[7:0], tab[i].q);
    end

    // illegal dimensions, then a legal pass clears err
    run_pass(0, 5, 4, 1'b0, -1);
    run_pass(40, 30, 4, 1'b0, -1);
    fill(2);
    run_pass(1, 2, 3, 1'b1, -1);

    // start while busy is ignored
    fill(9);
    run_pass(3, 3, 2, 1'b1, 2);

    // reset mid-pass
    fill(16);
    clear_mon();
    bus.H = 6'd4; bus.W = 6'd4; bus.shift = 5'd1; bus.relu_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && wr_q.size() < 3; i++) tick();
    chk("pre_rst_writes", wr_q.size(), 3);
    rst_n = 1'b1;
    #1;
    chk("midrst_ctrl", {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.err}, 0);
    chk("midrst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    chk("midrst_wdata", bus.wr_data, 0);
    tick(); tick();
    rst_n = 1'b0;
    repeat (8) tick();
    chk("post_rst_writes", wr_q.size(), 3);
    chk("post_rst_done", done_cyc.size(), 0);
    run_pass(4, 4, 1, 1'b0, -1);

    // randomized passes
    for (int r = 0; r < 6; r++) begin
      int h, w;
      h = $urandom_range(1, 5);
      w = $urandom_range(1, 5);
      fill(h * w);
      run_pass(h, w, $urandom_range(0, 31), 1'($urandom_range(0, 1)), -1);
    end

    // largest legal map
    fill(1024);
    run_pass(32, 32, 7, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
